aes_ctr_xor_stage: RTL and testbench
====================================

# aes_ctr_xor_stage

Final datapath stage of the AES-256-CTR core: joins the plaintext AXI-Stream with the keystream produced by the AES round pipeline, XORs them word by word, and presents ciphertext on an AXI-Stream master with tlast passthrough and full backpressure support. Its master port is the ciphertext stream checked by the verification consumer, so every beat and tlast position must match the golden ciphertext files exactly.

## Interface
- DATA_WIDTH, 128, width of plaintext, keystream and ciphertext words.
- CNT_WIDTH, 32, width of the per-packet beat counter.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_pt_tdata  in  DATA_WIDTH  plaintext word.
- s_pt_tvalid  in  1  plaintext valid.
- s_pt_tlast  in  1  last plaintext word of packet.
- s_pt_tready  out  1  plaintext accepted.
- s_ks_tdata  in  DATA_WIDTH  keystream word (AES(counter)).
- s_ks_tvalid  in  1  keystream valid.
- s_ks_tready  out  1  keystream accepted.
- m_axis_tdata  out  DATA_WIDTH  ciphertext word.
- m_axis_tvalid  out  1  ciphertext valid.
- m_axis_tlast  out  1  last ciphertext word of packet.
- m_axis_tready  in  1  downstream ready.
- beat_count  out  CNT_WIDTH  ciphertext beats transferred in current packet.
- pkt_done  out  1  one-cycle pulse after the tlast beat transfers on m_axis.

## Operation
- Join: a word pair is consumed ("join fire") when s_pt_tvalid & s_ks_tvalid & can_accept. s_pt_tready = s_ks_tvalid & can_accept; s_ks_tready = s_pt_tvalid & can_accept. Neither input is consumed alone.
- Keystream carries no tlast; packet boundaries come only from s_pt_tlast. Keystream words are consumed one-for-one with plaintext, including the tlast word.
- Data: ciphertext = s_pt_tdata ^ s_ks_tdata, registered with s_pt_tlast.
- Output buffer (skid build): main register drives m_axis_*; skid register catches a join fire made while main is valid and stalled. States EMPTY (0 words), ONE (main valid), FULL (main + skid valid). can_accept = state != FULL (registered, no combinational path from m_axis_tready).
  - EMPTY: join -> ONE.
  - ONE: join & !m_fire -> FULL; join & m_fire -> ONE (main reloaded); !join & m_fire -> EMPTY.
  - FULL: m_fire -> ONE, skid moves to main; no join possible.
- m_fire = m_axis_tvalid & m_axis_tready. m_axis_tdata/tlast stable while tvalid & !tready.
- beat_count increments on each m_fire; on m_fire with m_axis_tlast it clears to 0 and pkt_done asserts next cycle for exactly one cycle. Count wraps modulo 2^CNT_WIDTH within a packet (no saturation).
- Back-to-back packets: first beat of the next packet may transfer in the cycle after a tlast beat; no idle cycle inserted.

## Timing
- Reset (rst_n low, asynchronous): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_pt_tready=0, s_ks_tready=0 while asserted, beat_count=0, pkt_done=0, state EMPTY. Reset mid-packet discards buffered words; no partial-packet recovery.
- Latency: join fire in cycle N -> m_axis_tvalid in cycle N+1.
- Throughput: one word per cycle sustained while m_axis_tready=1 and both inputs valid.
- Simultaneous join fire and m_fire in ONE: both take effect, state stays ONE.
- Inputs may drop tvalid at any time; outputs never drop tvalid before m_fire.

## Configuration
- AES_CTR_XOR_SKID_EN defined: two-entry skid buffer as above; input readies are registered.
- Undefined: single output register only; can_accept = !m_axis_tvalid | m_axis_tready (combinational path from m_axis_tready to input readies); states reduce to EMPTY/ONE; full throughput and identical data/tlast/beat_count/pkt_done behaviour.

## Test plan
- Reset then 4-word packet, pt=0x0..00,01,02,03 (tlast on 4th), ks=0xFF..FF each, m_axis_tready=1 -> ciphertext 0xFF..FF,FE,FD,FC in consecutive cycles, tlast on 4th, beat_count 1,2,3 then 0, pkt_done pulse one cycle later.
- Keystream valid 3 cycles after plaintext -> no input consumed until both valid; s_pt_tready=0 meanwhile; first ciphertext one cycle after join.
- m_axis_tready held low 5 cycles with inputs streaming -> (skid build) exactly 2 words buffered, input readies low, m_axis_tdata stable; on release, words emerge in order with no loss or duplication.
- Random tvalid/tready toggling (50% each) over 64-word packet against golden ciphertext file -> all words match, tlast only on word 63, beat_count 64 transfers then 0.
- Back-to-back 1-word packets, tlast on every word -> pkt_done pulses each cycle after a transfer, beat_count stays 0.
- rst_n asserted asynchronously with FULL buffer mid-packet -> m_axis_tvalid falls immediately; after release next packet produces correct ciphertext from word 0.

Source files
------------

// File: rtl/aes_ctr_xor_stage.sv
// ============================================================================
// aes_ctr_xor_stage
// ----------------------------------------------------------------------------
// Final datapath stage of the AES-256-CTR core. Joins the plaintext stream
// with the keystream coming out of the AES round pipeline, XORs each
// plaintext word with its keystream word and presents the ciphertext on an
// AXI-Stream master port. tlast comes from the plaintext side only, and
// backpressure from the master port is fully supported.
//
// Build option:
//   AES_CTR_XOR_SKID_EN  defined   -> two-entry output buffer (main + skid).
//                                     Input readies come from a register, so
//                                     there is no combinational path from
//                                     m_axis_tready to the input readies.
//                        undefined -> single output register. Input readies
//                                     depend combinationally on
//                                     m_axis_tready. Throughput and output
//                                     behaviour are the same in both builds.
//
// Parameters:
//   DATA_WIDTH   width of plaintext, keystream and ciphertext words
//   CNT_WIDTH    width of the per-packet beat counter
//
// Ports:
//   clk, rst_n        clock (rising edge) / asynchronous active-low reset
//   s_pt_*            plaintext AXI-Stream slave (tdata, tvalid, tlast, tready)
//   s_ks_*            keystream AXI-Stream slave (tdata, tvalid, tready)
//   m_axis_*          ciphertext AXI-Stream master (tdata, tvalid, tlast, tready)
//   beat_count        ciphertext beats transferred so far in the current packet
//   pkt_done          one-cycle pulse in the cycle after the tlast beat transfers
// ============================================================================

module aes_ctr_xor_stage #(
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] s_pt_tdata,
    input  logic                  s_pt_tvalid,
    input  logic                  s_pt_tlast,
    output logic                  s_pt_tready,

    input  logic [DATA_WIDTH-1:0] s_ks_tdata,
    input  logic                  s_ks_tvalid,
    output logic                  s_ks_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic                  pkt_done
);

    // Output buffer occupancy. ST_FULL is only reachable in the skid build.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic                  can_accept;
    logic                  join_fire;
    logic                  m_fire;
    logic [DATA_WIDTH-1:0] xor_word;

    logic [DATA_WIDTH-1:0] main_data;
    logic                  main_last;

    // The two inputs are consumed strictly as a pair: each side's ready
    // depends on the other side's valid, so a word is never taken from one
    // stream without its partner from the other.
    assign xor_word      = s_pt_tdata ^ s_ks_tdata;
    assign join_fire     = s_pt_tvalid & s_ks_tvalid & can_accept;
    assign s_pt_tready   = s_ks_tvalid & can_accept;
    assign s_ks_tready   = s_pt_tvalid & can_accept;

    // The main register is always the word on the master port; it is valid
    // whenever the buffer holds anything.
    assign m_axis_tvalid = (state != ST_EMPTY);
    assign m_axis_tdata  = main_data;
    assign m_axis_tlast  = main_last;
    assign m_fire        = m_axis_tvalid & m_axis_tready;

`ifdef AES_CTR_XOR_SKID_EN

    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;
    logic                  can_accept_q;

    // can_accept_q resets low, which also keeps both input readies low for
    // the whole time rst_n is asserted.
    assign can_accept = can_accept_q;

    // Next occupancy of the two-entry buffer. In ST_FULL can_accept is low,
    // so no join can happen there and only the drain of main matters.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (join_fire) begin
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (join_fire && !m_fire) begin
                    state_nxt = ST_FULL;
                end else if (!join_fire && m_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (m_fire) begin
                    state_nxt = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Buffer registers. A join that arrives while main is stalled lands in
    // the skid register. A join that arrives while main is being taken
    // reloads main directly. When main drains from ST_FULL the skid word
    // moves forward. can_accept is registered from the next occupancy, so
    // it always equals (state != ST_FULL) without looking at m_axis_tready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            can_accept_q <= 1'b0;
            main_data    <= '0;
            main_last    <= 1'b0;
            skid_data    <= '0;
            skid_last    <= 1'b0;
        end else begin
            state        <= state_nxt;
            can_accept_q <= (state_nxt != ST_FULL);
            case (state)
                ST_EMPTY: begin
                    if (join_fire) begin
                        main_data <= xor_word;
                        main_last <= s_pt_tlast;
                    end
                end
                ST_ONE: begin
                    if (join_fire) begin
                        if (m_fire) begin
                            main_data <= xor_word;
                            main_last <= s_pt_tlast;
                        end else begin
                            skid_data <= xor_word;
                            skid_last <= s_pt_tlast;
                        end
                    end
                end
                ST_FULL: begin
                    if (m_fire) begin
                        main_data <= skid_data;
                        main_last <= skid_last;
                    end
                end
                default: begin
                    main_data <= main_data;
                end
            endcase
        end
    end

`else

    // A new pair can enter when the output register is empty or is being
    // taken this cycle. This makes a combinational path from m_axis_tready
    // to the input readies. rst_n is included so that the readies stay low
    // while reset is asserted.
    assign can_accept = rst_n & (!m_axis_tvalid | m_axis_tready);

    // Single-register occupancy. A join in ST_ONE is only possible together
    // with m_fire, so the register is reloaded and the state stays ST_ONE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: begin
                if (join_fire) begin
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (!join_fire && m_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Output register: loaded on every join. It keeps its value while it is
    // stalled, because no join can happen then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            main_last <= 1'b0;
        end else begin
            state <= state_nxt;
            if (join_fire) begin
                main_data <= xor_word;
                main_last <= s_pt_tlast;
            end
        end
    end

`endif

    // Per-packet beat counter and end-of-packet pulse. Both are shared by the
    // two builds. The counter wraps naturally, has no saturation, and clears
    // on the tlast beat so that the next packet starts from zero with no idle
    // cycle. pkt_done is a registered copy of the tlast transfer, so it is
    // high for exactly the cycle after that transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
            pkt_done   <= 1'b0;
        end else begin
            pkt_done <= m_fire & m_axis_tlast;
            if (m_fire) begin
                if (m_axis_tlast) begin
                    beat_count <= '0;
                end else begin
                    beat_count <= beat_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_ctr_xor_stage.sv
// ============================================================================
// tb_aes_ctr_xor_stage
// ----------------------------------------------------------------------------
// Testbench for aes_ctr_xor_stage. A monitor running on the falling clock
// edge pushes the expected ciphertext word (the plaintext word XOR the
// keystream word, with tlast) into a queue on every join. It pops and
// compares an entry on every master transfer. It also models beat_count and
// pkt_done cycle by cycle and checks that m_axis data stays stable while the
// port is stalled. Each scenario task drives its own stimulus and checks
// things that are specific to that scenario.
// ============================================================================

module tb_aes_ctr_xor_stage;

    localparam int DW = 128;
    localparam int CW = 32;

`ifdef AES_CTR_XOR_SKID_EN
    localparam int EXP_BUF = 2;
`else
    localparam int EXP_BUF = 1;
`endif

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_pt_tdata;
    logic          s_pt_tvalid;
    logic          s_pt_tlast;
    logic          s_pt_tready;
    logic [DW-1:0] s_ks_tdata;
    logic          s_ks_tvalid;
    logic          s_ks_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [CW-1:0] beat_count;
    logic          pkt_done;

    int            checks = 0;
    int            errors = 0;

    beat_t         sb[$];
    logic [DW-1:0] out_log[$];
    int            join_cnt = 0;
    int            fire_cnt = 0;
    int            pd_cnt   = 0;
    bit            mon_en   = 0;
    logic [CW-1:0] exp_bc   = '0;
    logic          exp_pd   = 1'b0;
    bit            hold_pend = 0;
    logic [DW-1:0] hold_d;
    logic          hold_l;

    aes_ctr_xor_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_pt_tdata   (s_pt_tdata),
        .s_pt_tvalid  (s_pt_tvalid),
        .s_pt_tlast   (s_pt_tlast),
        .s_pt_tready  (s_pt_tready),
        .s_ks_tdata   (s_ks_tdata),
        .s_ks_tvalid  (s_ks_tvalid),
        .s_ks_tready  (s_ks_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .beat_count   (beat_count),
        .pkt_done     (pkt_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls forever.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not reach its end, required completion");
        $fatal(1, "[TB] global timeout");
    end

    // Scoreboard and cycle-level model, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (beat_count !== exp_bc) begin
                errors++;
                $display("[TB] FAIL beat_count: got %0d, required %0d", beat_count, exp_bc);
            end
            checks++;
            if (pkt_done !== exp_pd) begin
                errors++;
                $display("[TB] FAIL pkt_done: got %b, required %b", pkt_done, exp_pd);
            end
            if (pkt_done === 1'b1) pd_cnt++;

            if (hold_pend) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d || m_axis_tlast !== hold_l) begin
                    errors++;
                    $display("[TB] FAIL stall_stable: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, hold_d, hold_l);
                end
            end
            hold_pend = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
            hold_d    = m_axis_tdata;
            hold_l    = m_axis_tlast;

            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                beat_t e;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got d=%h, required no output", m_axis_tdata);
                end else begin
                    e = sb.pop_front();
                    if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
                        errors++;
                        $display("[TB] FAIL ciphertext: got d=%h l=%b, required d=%h l=%b",
                                 m_axis_tdata, m_axis_tlast, e.data, e.last);
                    end
                end
                out_log.push_back(m_axis_tdata);
                fire_cnt++;
                exp_pd = m_axis_tlast;
                exp_bc = m_axis_tlast ? '0 : exp_bc + 1;
            end else begin
                exp_pd = 1'b0;
            end

            if ((s_pt_tvalid && s_pt_tready) !== (s_ks_tvalid && s_ks_tready)) begin
                checks++;
                errors++;
                $display("[TB] FAIL join_pair: got pt_fire=%b ks_fire=%b, required equal",
                         s_pt_tvalid && s_pt_tready, s_ks_tvalid && s_ks_tready);
            end
            if (s_pt_tvalid && s_pt_tready && s_ks_tvalid && s_ks_tready) begin
                sb.push_back({s_pt_tlast, s_pt_tdata ^ s_ks_tdata});
                join_cnt++;
            end
        end
    end

    // Drain the output. Fails if the queue does not empty within the budget.
    task automatic wait_drain();
        bit done = 0;
        s_pt_tvalid   = 1'b0;
        s_ks_tvalid   = 1'b0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && m_axis_tvalid === 1'b0) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    // Stream n word pairs with the given valid and ready percentages.
    // Plaintext word i is pt_base+i and keystream word i is ks_base+i*ks_step.
    // tlast is set on every plen-th plaintext word. Returns the number of
    // driven cycles.
    task automatic stream(input int n, input int plen,
                          input logic [DW-1:0] pt_base, input logic [DW-1:0] ks_base,
                          input logic [DW-1:0] ks_step,
                          input int pv, input int kv, input int rv, output int cycles);
        int pi = 0;
        int ki = 0;
        bit pa, ka;
        cycles = 0;
        while ((pi < n || ki < n) && cycles < 4000) begin
            s_pt_tvalid   = (pi < n) && ($urandom_range(0, 99) < pv);
            s_pt_tdata    = pt_base + DW'(pi);
            s_pt_tlast    = ((pi % plen) == plen - 1);
            s_ks_tvalid   = (ki < n) && ($urandom_range(0, 99) < kv);
            s_ks_tdata    = ks_base + ks_step * DW'(ki);
            m_axis_tready = ($urandom_range(0, 99) < rv);
            @(negedge clk);
            pa = s_pt_tvalid && s_pt_tready;
            ka = s_ks_tvalid && s_ks_tready;
            @(posedge clk); #1;
            cycles++;
            if (pa) pi++;
            if (ka) ki++;
        end
        s_pt_tvalid = 1'b0;
        s_ks_tvalid = 1'b0;
        checks++;
        if (pi != n || ki != n) begin
            errors++;
            $display("[TB] FAIL stream_timeout: got pt=%0d ks=%0d, required %0d", pi, ki, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_pt_tvalid = 1'b1; s_ks_tvalid = 1'b1;
        s_pt_tdata = '1; s_ks_tdata = '0; s_pt_tlast = 1'b0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 ||
            s_pt_tready !== 1'b0 || s_ks_tready !== 1'b0 || beat_count !== '0 || pkt_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%b l=%b d=%h ptr=%b ksr=%b bc=%0d pd=%b, required all 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_pt_tready, s_ks_tready, beat_count, pkt_done);
        end
        s_pt_tvalid = 1'b0; s_ks_tvalid = 1'b0;
        #3 rst_n = 1'b1;
        mon_en = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int cyc;
        logic [DW-1:0] e;
        out_log.delete();
        stream(4, 4, '0, '1, '0, 100, 100, 100, cyc);
        checks++;
        if (cyc != 4) begin
            errors++;
            $display("[TB] FAIL basic_throughput: got %0d cycles, required 4", cyc);
        end
        wait_drain();
        checks++;
        if (out_log.size() != 4) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d words, required 4", out_log.size());
        end
        for (int k = 0; k < 4 && k < out_log.size(); k++) begin
            e = {DW{1'b1}} ^ DW'(k);
            checks++;
            if (out_log[k] !== e) begin
                errors++;
                $display("[TB] FAIL basic_word%0d: got %h, required %h", k, out_log[k], e);
            end
        end
    endtask

    task automatic test_ks_delay();
        int j0 = join_cnt;
        m_axis_tready = 1'b1;
        s_pt_tdata = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
        s_pt_tlast = 1'b1;
        s_pt_tvalid = 1'b1;
        s_ks_tdata = 128'hA5A5_A5A5_5A5A_5A5A_F0F0_F0F0_0F0F_0F0F;
        s_ks_tvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (s_pt_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL ks_wait: got ptr=%b v=%b, required 0 0", s_pt_tready, m_axis_tvalid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (join_cnt != j0) begin
            errors++;
            $display("[TB] FAIL ks_wait_join: got %0d joins, required 0", join_cnt - j0);
        end
        s_ks_tvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (s_pt_tready !== 1'b1 || s_ks_tready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ks_join_ready: got ptr=%b ksr=%b, required 1 1", s_pt_tready, s_ks_tready);
        end
        @(posedge clk); #1;
        s_pt_tvalid = 1'b0; s_ks_tvalid = 1'b0;
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ks_latency: got tvalid=%b, required 1", m_axis_tvalid);
        end
        wait_drain();
    endtask

    task automatic test_stall();
        int j0 = join_cnt;
        int f0;
        int idx = 0;
        bit acc;
        m_axis_tready = 1'b0;
        repeat (5) begin
            s_pt_tvalid = 1'b1; s_ks_tvalid = 1'b1;
            s_pt_tdata = 128'h1000 + DW'(idx);
            s_ks_tdata = 128'hDEAD_BEEF_0000_0000_0000_0000_0000_0000 + DW'(idx * 7);
            s_pt_tlast = 1'b1;
            @(negedge clk);
            acc = s_pt_tvalid && s_pt_tready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        checks++;
        if (join_cnt - j0 != EXP_BUF) begin
            errors++;
            $display("[TB] FAIL stall_buffered: got %0d words, required %0d", join_cnt - j0, EXP_BUF);
        end
        checks++;
        if (s_pt_tready !== 1'b0 || s_ks_tready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_ready: got ptr=%b ksr=%b, required 0 0", s_pt_tready, s_ks_tready);
        end
        f0 = fire_cnt;
        wait_drain();
        checks++;
        if (fire_cnt - f0 != EXP_BUF) begin
            errors++;
            $display("[TB] FAIL stall_release: got %0d words, required %0d", fire_cnt - f0, EXP_BUF);
        end
    endtask

    task automatic test_random();
        int cyc;
        int f0 = fire_cnt;
        int p0 = pd_cnt;
        stream(64, 64, 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0,
               128'h6A09_E667_BB67_AE85_3C6E_F372_A54F_F53A,
               128'h0000_0001_0000_0003_0000_0005_0000_0007, 50, 50, 50, cyc);
        wait_drain();
        checks++;
        if (fire_cnt - f0 != 64 || pd_cnt - p0 != 1 || beat_count !== '0) begin
            errors++;
            $display("[TB] FAIL random_packet: got %0d beats %0d pulses bc=%0d, required 64 1 0",
                     fire_cnt - f0, pd_cnt - p0, beat_count);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int p0 = pd_cnt;
        stream(8, 1, 128'h5555, 128'h3333_0000, 128'h11, 100, 100, 100, cyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("[TB] FAIL b2b_throughput: got %0d cycles, required 8", cyc);
        end
        wait_drain();
        checks++;
        if (pd_cnt - p0 != 8) begin
            errors++;
            $display("[TB] FAIL b2b_pulses: got %0d, required 8", pd_cnt - p0);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        logic [DW-1:0] e;
        m_axis_tready = 1'b0;
        s_pt_tvalid = 1'b1; s_ks_tvalid = 1'b1;
        s_pt_tdata = 128'h77; s_ks_tdata = 128'h99; s_pt_tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_pre: got tvalid=%b, required 1", m_axis_tvalid);
        end
        #2;
        mon_en = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || s_pt_tready !== 1'b0 ||
            s_ks_tready !== 1'b0 || beat_count !== '0 || pkt_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_state: got v=%b d=%h ptr=%b ksr=%b bc=%0d pd=%b, required all 0",
                     m_axis_tvalid, m_axis_tdata, s_pt_tready, s_ks_tready, beat_count, pkt_done);
        end
        s_pt_tvalid = 1'b0; s_ks_tvalid = 1'b0;
        sb.delete(); out_log.delete();
        exp_bc = '0; exp_pd = 1'b0; hold_pend = 0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        mon_en = 1;
        @(posedge clk); #1;
        stream(4, 4, 128'hC0DE_0000, 128'h0BAD_F00D, 128'h100, 100, 100, 100, cyc);
        wait_drain();
        e = 128'hC0DE_0000 ^ 128'h0BAD_F00D;
        checks++;
        if (out_log.size() != 4 || out_log[0] !== e) begin
            errors++;
            $display("[TB] FAIL areset_recover: got %0d words first=%h, required 4 first=%h",
                     out_log.size(), (out_log.size() > 0) ? out_log[0] : '0, e);
        end
    endtask

    initial begin
        s_pt_tdata = '0; s_pt_tvalid = 1'b0; s_pt_tlast = 1'b0;
        s_ks_tdata = '0; s_ks_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_basic();
        test_ks_delay();
        test_stall();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
